// File: rtl/operand_fetch_stage_pkg.sv
// Shared definitions for the issue/ALU/decoder slice: default widths and the
// ALU operation encoding that the decoder emits and the ALU consumes.
package operand_fetch_stage_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_RADDR_W = 3;
  localparam int DEF_OP_W    = 3;

  typedef enum logic [DEF_OP_W-1:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd3,
    ALU_SLT = 3'd4,
    ALU_NOR = 3'd5,
    ALU_SEQ = 3'd6
  } alu_op_e;

endpackage

// File: rtl/operand_fetch_stage_reg_file.sv
// General register file: two asynchronous read ports, one synchronous write
// port, R0 hardwired to zero. With WB_BYPASS_EN defined, a read of the register
// being written this cycle returns the incoming write data (write-before-read).
module operand_fetch_stage_reg_file
  import operand_fetch_stage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RADDR_W-1:0] rs_addr_i,
  input  logic [RADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0]  rs_data_o,
  output logic [DATA_W-1:0]  rt_data_o,
  input  logic               wb_en_i,
  input  logic [RADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0]  wb_data_i
);

  localparam int NREGS = 2 ** RADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wb_hit;

  // A write to R0 is a legal no-op, so it is filtered before reaching the array.
  assign wb_hit = wb_en_i && (wb_addr_i != '0);

  // Register array: cleared on reset, written on the writeback strobe.
  // NOTE: the file is architecturally zero after reset, so the array carries a
  // reset; a storage array without that need should stay reset-free so it can
  // map onto RAM. Sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_hit) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  // Read port A: R0 forced to zero, optional same-cycle writeback forwarding.
  // NOTE: the output is assigned first on every path so no latch is inferred.
  always_comb begin
    rs_data_o = (rs_addr_i == '0) ? '0 : regs_q[rs_addr_i];
`ifdef WB_BYPASS_EN
    if (wb_hit && (wb_addr_i == rs_addr_i)) rs_data_o = wb_data_i;
`endif
  end

  // Read port B: same rules as port A, evaluated independently.
  always_comb begin
    rt_data_o = (rt_addr_i == '0) ? '0 : regs_q[rt_addr_i];
`ifdef WB_BYPASS_EN
    if (wb_hit && (wb_addr_i == rt_addr_i)) rt_data_o = wb_data_i;
`endif
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch / issue stage in front of the 8-bit ALU. Accepts decoded
// instructions on a valid/ready handshake, reads rs/rt from the register file
// (opB optionally replaced by the immediate) and presents a one-entry
// registered output slot. Writebacks are never stalled by the handshake.
// Optional build macro: WB_BYPASS_EN (same-cycle writeback forwarding).
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int OP_W    = DEF_OP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RADDR_W-1:0] rs_addr,
  input  logic [RADDR_W-1:0] rt_addr,
  input  logic [DATA_W-1:0]  imm,
  input  logic               use_imm,
  input  logic [OP_W-1:0]    alu_op_in,
  input  logic [RADDR_W-1:0] rd_addr_in,
  input  logic               rd_we_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  opA,
  output logic [DATA_W-1:0]  opB,
  output logic [OP_W-1:0]    ALUop,
  output logic [RADDR_W-1:0] rd_addr_out,
  output logic               rd_we_out,
  input  logic               wb_en,
  input  logic [RADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]  wb_data
);

  logic [DATA_W-1:0]  rs_data, rt_data;
  logic               accept;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  opa_q, opa_d, opb_q, opb_d;
  logic [OP_W-1:0]    alu_op_q, alu_op_d;
  logic [RADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic               rd_we_q, rd_we_d;

  operand_fetch_stage_reg_file #(
    .DATA_W  (DATA_W),
    .RADDR_W (RADDR_W)
  ) u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .rs_addr_i (rs_addr),
    .rt_addr_i (rt_addr),
    .rs_data_o (rs_data),
    .rt_data_o (rt_data),
    .wb_en_i   (wb_en),
    .wb_addr_i (wb_addr),
    .wb_data_i (wb_data)
  );

  // The slot can take a new instruction when empty or being drained this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Next slot contents: capture on accept, drop valid on a bare consume,
  // otherwise hold everything (data outputs keep their value after consume).
  always_comb begin
    out_valid_d = out_valid_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    alu_op_d    = alu_op_q;
    rd_addr_d   = rd_addr_q;
    rd_we_d     = rd_we_q;
    if (accept) begin
      out_valid_d = 1'b1;
      opa_d       = rs_data;
      opb_d       = use_imm ? imm : rt_data;
      alu_op_d    = alu_op_in;
      rd_addr_d   = rd_addr_in;
      rd_we_d     = rd_we_in;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output slot register; reset drops any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      alu_op_q    <= '0;
      rd_addr_q   <= '0;
      rd_we_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      alu_op_q    <= alu_op_d;
      rd_addr_q   <= rd_addr_d;
      rd_we_q     <= rd_we_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign opA         = opa_q;
  assign opB         = opb_q;
  assign ALUop       = alu_op_q;
  assign rd_addr_out = rd_addr_q;
  assign rd_we_out   = rd_we_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed scenarios plus a
// randomized run, all compared against a behavioural model of the register
// file and the one-entry output slot. Honours WB_BYPASS_EN like the RTL.
module tb_operand_fetch_stage;
  import operand_fetch_stage_pkg::*;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, use_imm, rd_we_in;
  logic          out_valid, out_ready, rd_we_out, wb_en;
  logic [AW-1:0] rs_addr, rt_addr, rd_addr_in, rd_addr_out, wb_addr;
  logic [DW-1:0] imm, opA, opB, wb_data;
  logic [OW-1:0] alu_op_in, ALUop;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model state
  logic [DW-1:0] m_regs [8];
  logic          m_valid;
  logic [DW-1:0] m_opa, m_opb;
  logic [OW-1:0] m_op;
  logic [AW-1:0] m_rd;
  logic          m_we;
  logic          obs_ready, exp_ready;

  always #5 clk = ~clk;

  operand_fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .imm         (imm),
    .use_imm     (use_imm),
    .alu_op_in   (alu_op_in),
    .rd_addr_in  (rd_addr_in),
    .rd_we_in    (rd_we_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .opA         (opA),
    .opB         (opB),
    .ALUop       (ALUop),
    .rd_addr_out (rd_addr_out),
    .rd_we_out   (rd_we_out),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data)
  );

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef WB_BYPASS_EN
    if (wb_en && wb_addr == a) return wb_data;
`endif
    return m_regs[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_valid = 1'b0; m_opa = '0; m_opb = '0; m_op = '0; m_rd = '0; m_we = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0; out_ready = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    rs_addr = '0; rt_addr = '0; imm = '0; use_imm = 1'b0;
    alu_op_in = '0; rd_addr_in = '0; rd_we_in = 1'b0;
  endtask

  task automatic set_instr(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                           input logic ui, input logic [DW-1:0] im,
                           input logic [OW-1:0] op, input logic [AW-1:0] rd);
    in_valid = 1'b1; rs_addr = rs; rt_addr = rt; use_imm = ui; imm = im;
    alu_op_in = op; rd_addr_in = rd; rd_we_in = 1'b1;
  endtask

  // Advance one clock: sample in_ready, update the model from the rules, clock.
  task automatic step();
    logic [DW-1:0] a, b;
    logic          acc;
    #1;
    obs_ready = in_ready;
    exp_ready = !m_valid || out_ready;
    acc = in_valid && exp_ready;
    a = m_read(rs_addr);
    b = use_imm ? imm : m_read(rt_addr);
    if (acc) begin
      m_valid = 1'b1; m_opa = a; m_opb = b; m_op = alu_op_in; m_rd = rd_addr_in; m_we = rd_we_in;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    m_reset();
    rst = 1'b1;
    #3;
    n_total++;
    if ({out_valid, opA, opB, ALUop, rd_addr_out, rd_we_out} !== '0)
      $display("FAIL reset_outputs: got v=%b a=%h b=%h op=%h rd=%h we=%b want all zero",
               out_valid, opA, opB, ALUop, rd_addr_out, rd_we_out);
    else n_pass++;
    #9 rst = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_writeback_read();
    idle();
    wb_en = 1'b1; wb_addr = 3'd3; wb_data = 8'h5A;
    step();
    idle();
    set_instr(3'd3, 3'd0, 1'b0, 8'h00, ALU_ADD, 3'd4);
    step();
    idle();
    n_total++;
    if ({out_valid, opA, opB, ALUop} !== {1'b1, 8'h5A, 8'h00, 3'd2})
      $display("FAIL wb_then_issue: got v=%b a=%h b=%h op=%0d want v=1 a=5a b=00 op=2",
               out_valid, opA, opB, ALUop);
    else n_pass++;
  endtask

  task automatic test_r0();
    idle();
    wb_en = 1'b1; wb_addr = 3'd0; wb_data = 8'hFF;
    step();
    idle();
    set_instr(3'd0, 3'd0, 1'b0, 8'h00, ALU_OR, 3'd1);
    step();
    idle();
    n_total++;
    if ({opA, opB} !== 16'h0000) $display("FAIL r0_zero: got a=%h b=%h want 00 00", opA, opB);
    else n_pass++;
  endtask

  task automatic test_stall_back_to_back();
    idle();
    set_instr(3'd1, 3'd3, 1'b1, 8'h7F, ALU_SUB, 3'd5);
    step();
    n_total++;
    if ({out_valid, opB, ALUop} !== {1'b1, 8'h7F, 3'd3})
      $display("FAIL imm_issue: got v=%b b=%h op=%0d want v=1 b=7f op=3", out_valid, opB, ALUop);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      set_instr(3'd3, 3'd3, 1'b0, 8'h00, ALU_NOR, 3'd6);
      out_ready = 1'b0;
      step();
      n_total++;
      if (obs_ready !== 1'b0 || {out_valid, opB, ALUop, rd_addr_out} !== {1'b1, 8'h7F, 3'd3, 3'd5})
        $display("FAIL stall_hold cyc %0d: got rdy=%b v=%b b=%h op=%0d rd=%0d want rdy=0 v=1 b=7f op=3 rd=5",
                 c, obs_ready, out_valid, opB, ALUop, rd_addr_out);
      else n_pass++;
    end
    out_ready = 1'b1;
    step();
    n_total++;
    if (obs_ready !== 1'b1 || {out_valid, opA, opB, ALUop, rd_addr_out} !== {1'b1, 8'h5A, 8'h5A, 3'd5, 3'd6})
      $display("FAIL back_to_back: got rdy=%b v=%b a=%h b=%h op=%0d rd=%0d want rdy=1 v=1 a=5a b=5a op=5 rd=6",
               obs_ready, out_valid, opA, opB, ALUop, rd_addr_out);
    else n_pass++;
    idle();
    step();
    n_total++;
    if ({out_valid, opA} !== {1'b0, 8'h5A})
      $display("FAIL drain_hold: got v=%b a=%h want v=0 a=5a", out_valid, opA);
    else n_pass++;
  endtask

  task automatic test_bypass();
    logic [DW-1:0] want;
    idle();
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 8'h22;
    step();
    idle();
    set_instr(3'd2, 3'd2, 1'b0, 8'h00, ALU_AND, 3'd7);
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 8'h11;
    step();
`ifdef WB_BYPASS_EN
    want = 8'h11;
`else
    want = 8'h22;
`endif
    n_total++;
    if (opA !== want || opB !== want)
      $display("FAIL same_cycle_wb: got a=%h b=%h want %h", opA, opB, want);
    else n_pass++;
    idle();
    set_instr(3'd2, 3'd0, 1'b0, 8'h00, ALU_AND, 3'd7);
    step();
    idle();
    n_total++;
    if (opA !== 8'h11) $display("FAIL wb_committed: got a=%h want 11", opA);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid   = 1'($urandom_range(0, 1));
      out_ready  = ($urandom_range(0, 3) != 0);
      rs_addr    = 3'($urandom);
      rt_addr    = 3'($urandom);
      imm        = 8'($urandom);
      use_imm    = 1'($urandom_range(0, 1));
      alu_op_in  = 3'($urandom_range(0, 6));
      rd_addr_in = 3'($urandom);
      rd_we_in   = 1'($urandom_range(0, 1));
      wb_en      = 1'($urandom_range(0, 1));
      wb_addr    = 3'($urandom);
      wb_data    = 8'($urandom);
      step();
      n_total++;
      if (obs_ready !== exp_ready ||
          {out_valid, opA, opB, ALUop, rd_addr_out, rd_we_out} !== {m_valid, m_opa, m_opb, m_op, m_rd, m_we})
        $display("FAIL random cyc %0d: got rdy=%b out=%h want rdy=%b out=%h", c, obs_ready,
                 {out_valid, opA, opB, ALUop, rd_addr_out, rd_we_out}, exp_ready,
                 {m_valid, m_opa, m_opb, m_op, m_rd, m_we});
      else n_pass++;
    end
    idle();
  endtask

  task automatic test_reset_mid_run();
    idle();
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 8'hC3;
    step();
    idle();
    set_instr(3'd5, 3'd5, 1'b0, 8'h00, ALU_SLT, 3'd2);
    step();
    idle();
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({out_valid, opA, opB, ALUop} !== '0)
      $display("FAIL mid_reset: got v=%b a=%h b=%h op=%0d want all zero", out_valid, opA, opB, ALUop);
    else n_pass++;
    #1 rst = 1'b0;
    m_reset();
    for (int r = 1; r < 8; r++) begin
      idle();
      set_instr(3'(r), 3'(r), 1'b0, 8'h00, ALU_AND, 3'd0);
      step();
      n_total++;
      if ({out_valid, opA, opB} !== {1'b1, m_regs[r], m_regs[r]})
        $display("FAIL post_reset R%0d: got v=%b a=%h b=%h want v=1 a=00 b=00", r, out_valid, opA, opB);
      else n_pass++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_writeback_read();
    test_r0();
    test_stall_back_to_back();
    test_bypass();
    test_random();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
